// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard that detects RAW hazards and drives pipeline stall and bubble controls.
// Define HDU_PERF_EN to build the saturating RAW/memory stall performance counters.
package hdu_pkg;
  typedef enum logic [1:0] {
    NO_STALL        = 2'd0,
    READ_AFTER_LOAD = 2'd1,
    MEM_DELAY_STALL = 2'd2
  } stall_debug_t;
endpackage

module hazard_scoreboard
  import hdu_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5,
  parameter int LAT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [IDX_W-1:0] iss_rs1,
  input  logic [IDX_W-1:0] iss_rs2,
  input  logic [IDX_W-1:0] iss_rd,
  input  logic             iss_we,
  input  logic [LAT_W-1:0] iss_lat,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_rd,
  input  logic             mem_stall,
  input  logic             flush,
  output logic             ctrlmux_sel,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             cur_stall,
  output stall_debug_t     sd,
  output logic [31:0]      raw_stall_cnt,
  output logic [31:0]      mem_stall_cnt
);

  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];

  logic rs1_busy;
  logic rs2_busy;
  logic raw_hazard;
  logic accept;
  logic issue_wr;

  assign rs1_busy   = (iss_rs1 != '0) && (cnt_q[iss_rs1] != '0);
  assign rs2_busy   = (iss_rs2 != '0) && (cnt_q[iss_rs2] != '0);
  assign raw_hazard = iss_valid && (rs1_busy || rs2_busy);
  assign accept     = iss_valid && !raw_hazard && !mem_stall && !flush;
  assign issue_wr   = accept && iss_we && (iss_rd != '0) &&
                      (iss_lat != '0);

  // Priority per entry: flush, issue write, writeback clear, decrement.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (flush) begin
        cnt_d[r] = '0;
      end else if (!mem_stall) begin
        if (issue_wr && (iss_rd == IDX_W'(r))) begin
          cnt_d[r] = iss_lat;
        end else if (wb_valid && (wb_rd == IDX_W'(r))) begin
          cnt_d[r] = '0;
        end else if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  always_comb begin
    ctrlmux_sel = 1'b0;
    load_pc     = 1'b1;
    load_if_id  = 1'b1;
    load_id_ex  = 1'b1;
    load_ex_mem = 1'b1;
    load_mem_wb = 1'b1;
    cur_stall   = 1'b0;
    sd          = NO_STALL;
    if (mem_stall) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      cur_stall   = 1'b1;
      sd          = MEM_DELAY_STALL;
    end else if (raw_hazard) begin
      ctrlmux_sel = 1'b1;
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      sd          = READ_AFTER_LOAD;
    end
  end

`ifdef HDU_PERF_EN
  logic [31:0] raw_cnt_q;
  logic [31:0] raw_cnt_d;
  logic [31:0] mem_cnt_q;
  logic [31:0] mem_cnt_d;

  always_comb begin
    raw_cnt_d = raw_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (raw_hazard && !mem_stall && (raw_cnt_q != '1)) begin
      raw_cnt_d = raw_cnt_q + 32'd1;
    end
    if (mem_stall && (mem_cnt_q != '1)) begin
      mem_cnt_d = mem_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_cnt_q <= '0;
      mem_cnt_q <= '0;
    end else begin
      raw_cnt_q <= raw_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign raw_stall_cnt = raw_cnt_q;
  assign mem_stall_cnt = mem_cnt_q;
`else
  assign raw_stall_cnt = '0;
  assign mem_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: RAW bubbles, memory freeze, writeback clear, flush, reset.
// Counter expectations follow HDU_PERF_EN when it is defined for the build.
module tb_hazard_scoreboard;
  import hdu_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         iss_valid;
  logic [4:0]   iss_rs1;
  logic [4:0]   iss_rs2;
  logic [4:0]   iss_rd;
  logic         iss_we;
  logic [2:0]   iss_lat;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic         mem_stall;
  logic         flush;
  logic         ctrlmux_sel;
  logic         load_pc;
  logic         load_if_id;
  logic         load_id_ex;
  logic         load_ex_mem;
  logic         load_mem_wb;
  logic         cur_stall;
  stall_debug_t sd;
  logic [31:0]  raw_stall_cnt;
  logic [31:0]  mem_stall_cnt;

  int checks = 0;
  int passed = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_we(iss_we), .iss_lat(iss_lat),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .mem_stall(mem_stall), .flush(flush),
    .ctrlmux_sel(ctrlmux_sel), .load_pc(load_pc),
    .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .cur_stall(cur_stall), .sd(sd),
    .raw_stall_cnt(raw_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0;
    iss_rd = '0; iss_we = 1'b0; iss_lat = '0;
    wb_valid = 1'b0; wb_rd = '0;
    mem_stall = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we,
                       input logic [2:0] lat);
    iss_valid = 1'b1; iss_rs1 = rs1; iss_rs2 = rs2;
    iss_rd = rd; iss_we = we; iss_lat = lat;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // mode: 0 no stall, 1 RAW bubble, 2 memory freeze
  task automatic chk_out(input string tag, input int mode);
    logic [4:0]   loads;
    logic [4:0]   exp_loads;
    logic         exp_ctrl;
    logic         exp_cur;
    stall_debug_t exp_sd;
    #1;
    loads = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
    case (mode)
      1: begin
        exp_ctrl = 1'b1; exp_loads = 5'b00111;
        exp_cur = 1'b0; exp_sd = READ_AFTER_LOAD;
      end
      2: begin
        exp_ctrl = 1'b0; exp_loads = 5'b00000;
        exp_cur = 1'b1; exp_sd = MEM_DELAY_STALL;
      end
      default: begin
        exp_ctrl = 1'b0; exp_loads = 5'b11111;
        exp_cur = 1'b0; exp_sd = NO_STALL;
      end
    endcase
    chk({tag, ".ctrl"}, 32'(ctrlmux_sel), 32'(exp_ctrl));
    chk({tag, ".loads"}, 32'(loads), 32'(exp_loads));
    chk({tag, ".cur"}, 32'(cur_stall), 32'(exp_cur));
    chk({tag, ".sd"}, 32'(sd), 32'(exp_sd));
  endtask

  task automatic chk_perf(input string tag, input int raw_n,
                          input int mem_n);
`ifdef HDU_PERF_EN
    chk({tag, ".raw"}, raw_stall_cnt, 32'(raw_n));
    chk({tag, ".mem"}, mem_stall_cnt, 32'(mem_n));
`else
    chk({tag, ".raw"}, raw_stall_cnt, 32'(raw_n - raw_n));
    chk({tag, ".mem"}, mem_stall_cnt, 32'(mem_n - mem_n));
`endif
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_out("reset", 0);
    chk_perf("reset_perf", 0, 0);
    issue(5'd3, 5'd17, 5'd0, 1'b0, 3'd0);
    chk_out("reset_read", 0);
    tick();

    // load x5 lat 1 then dependent: exactly one bubble
    issue(5'd1, 5'd2, 5'd5, 1'b1, 3'd1);
    chk_out("ld5_issue", 0);
    tick();
    issue(5'd5, 5'd0, 5'd10, 1'b1, 3'd0);
    chk_out("ld5_dep_c1", 1);
    tick();
    chk_out("ld5_dep_c2", 0);
    tick();

    // lat 3 on x7: three bubbles
    issue(5'd0, 5'd0, 5'd7, 1'b1, 3'd3);
    chk_out("x7_issue", 0);
    tick();
    issue(5'd0, 5'd7, 5'd0, 1'b0, 3'd0);
    chk_out("x7_dep_c1", 1);
    tick();
    chk_out("x7_dep_c2", 1);
    tick();
    chk_out("x7_dep_c3", 1);
    tick();
    chk_out("x7_dep_c4", 0);
    tick();

    // independent x8 while x7 busy
    issue(5'd0, 5'd0, 5'd7, 1'b1, 3'd3);
    tick();
    issue(5'd8, 5'd0, 5'd0, 1'b0, 3'd0);
    chk_out("x8_indep", 0);
    tick();
    idle();
    tick(); tick(); tick();

    // x5 at 2, memory freeze 4 cycles holds it
    issue(5'd0, 5'd0, 5'd5, 1'b1, 3'd2);
    tick();
    idle();
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) issue(5'd5, 5'd0, 5'd0, 1'b0, 3'd0);
      chk_out($sformatf("memstall_%0d", i), 2);
      tick();
    end
    idle();
    issue(5'd5, 5'd0, 5'd0, 1'b0, 3'd0);
    chk_out("x5_after_mem_c1", 1);
    tick();
    chk_out("x5_after_mem_c2", 1);
    tick();
    chk_out("x5_after_mem_c3", 0);
    tick();

    // x0 never tracked
    issue(5'd0, 5'd0, 5'd0, 1'b1, 3'd3);
    tick();
    issue(5'd0, 5'd0, 5'd0, 1'b0, 3'd0);
    chk_out("x0_read", 0);
    tick();

    // writeback clears x6 early
    issue(5'd0, 5'd0, 5'd6, 1'b1, 3'd3);
    tick();
    idle();
    wb_valid = 1'b1; wb_rd = 5'd6;
    tick();
    idle();
    issue(5'd6, 5'd0, 5'd0, 1'b0, 3'd0);
    chk_out("wb_x6_read", 0);
    tick();

    // issue write beats same-index writeback
    issue(5'd0, 5'd0, 5'd11, 1'b1, 3'd2);
    wb_valid = 1'b1; wb_rd = 5'd11;
    tick();
    idle();
    issue(5'd0, 5'd11, 5'd0, 1'b0, 3'd0);
    chk_out("x11_win_c1", 1);
    tick();
    chk_out("x11_win_c2", 1);
    tick();
    chk_out("x11_win_c3", 0);
    tick();

    // flush wipes x9
    issue(5'd0, 5'd0, 5'd9, 1'b1, 3'd3);
    tick();
    idle();
    flush = 1'b1;
    chk_out("flush_cycle", 0);
    tick();
    idle();
    issue(5'd9, 5'd0, 5'd0, 1'b0, 3'd0);
    chk_out("x9_after_flush", 0);
    tick();

    // flush suppresses concurrent write of x9
    issue(5'd0, 5'd0, 5'd9, 1'b1, 3'd3);
    flush = 1'b1;
    tick();
    idle();
    issue(5'd9, 5'd0, 5'd0, 1'b0, 3'd0);
    chk_out("x9_flush_wr", 0);
    tick();

    // flush applies during memory freeze
    issue(5'd0, 5'd0, 5'd12, 1'b1, 3'd3);
    tick();
    idle();
    mem_stall = 1'b1; flush = 1'b1;
    chk_out("flush_in_mem", 2);
    tick();
    idle();
    issue(5'd12, 5'd0, 5'd0, 1'b0, 3'd0);
    chk_out("x12_after_flush", 0);
    tick();
    idle();
    chk_perf("perf_totals", 8, 5);

    // reset during a freeze aborts it and clears state
    issue(5'd0, 5'd0, 5'd13, 1'b1, 3'd3);
    tick();
    idle();
    mem_stall = 1'b1; rst = 1'b1;
    chk_out("rst_in_mem", 2);
    tick();
    rst = 1'b0;
    idle();
    issue(5'd13, 5'd0, 5'd0, 1'b0, 3'd0);
    chk_out("x13_after_rst", 0);
    chk_perf("perf_after_rst", 0, 0);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
